execution_monitor: RTL

//  Synthesizable run-control monitor sitting beside the CPU in `system`. It samples PC, CPU fetch state,

---
 rtl/monitor_pkg.sv | 17 +
 rtl/trace_ring.sv | 94 +++++++++
 rtl/execution_monitor.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/monitor_pkg.sv
// Shared types for the execution monitor: FSM state encoding and trace entry sizing.
package monitor_pkg;

  // Run-control FSM states; halted/timeout are sticky until clear or reset.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StHalted  = 2'd2,
    StTimeout = 2'd3
  } mon_state_e;

  // A trace entry packs {address, data} into one word.
  function automatic int unsigned trace_entry_width(int unsigned addr_w, int unsigned data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/trace_ring.sv
// Ring buffer of the most recent memory writes with an oldest-relative registered read port.
module trace_ring
  import monitor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic [$clog2(TRACE_DEPTH):0]   count,
  output logic                           overflow
);

  localparam int unsigned PtrW   = $clog2(TRACE_DEPTH);
  localparam int unsigned EntryW = trace_entry_width(ADDR_WIDTH, DATA_WIDTH);

  logic [EntryW-1:0] mem_q [TRACE_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW:0]     count_q;
  logic              overflow_q;
  logic [EntryW-1:0] rd_entry_q;
  logic              rd_valid_q;

  logic              full;
  logic [PtrW-1:0]   oldest;
  logic [PtrW-1:0]   rd_phys;
  logic              rd_hit;

  // Depth is a power of two, so pointer arithmetic wraps naturally; when full the low
  // count bits are zero and the oldest entry is the one about to be overwritten.
  always_comb begin
    full    = (count_q == (PtrW + 1)'(TRACE_DEPTH));
    oldest  = wr_ptr_q - count_q[PtrW-1:0];
    rd_phys = oldest + rd_idx;
    rd_hit  = ({1'b0, rd_idx} < count_q);
  end

  // Storage array; no reset needed since count gates visibility of every entry.
  always_ff @(posedge clock) begin
    if (wr_en && !clear) begin
      mem_q[wr_ptr_q] <= {wr_addr, wr_data};
    end
  end

  // Write pointer, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (full) begin
        overflow_q <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Registered read; sees pre-write contents, and invalid slots read back as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_entry_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_hit;
      rd_entry_q <= rd_hit ? mem_q[rd_phys] : '0;
    end
  end

  // Port mapping.
  always_comb begin
    rd_addr  = rd_entry_q[EntryW-1:DATA_WIDTH];
    rd_data  = rd_entry_q[DATA_WIDTH-1:0];
    rd_valid = rd_valid_q;
    count    = count_q;
    overflow = overflow_q;
  end

endmodule

// File: rtl/execution_monitor.sv
// Run-control monitor beside the CPU: halt/timeout detection, cycle and retire counters,
// and a trace of recent memory writes.
module execution_monitor
  import monitor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned HALT_CYCLES    = 5,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned TRACE_DEPTH    = 8,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic [ADDR_WIDTH-1:0]          pc,
  input  logic                           fetch_state,
  input  logic                           retire,
  input  logic                           mem_write,
  input  logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_write_data,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [ADDR_WIDTH-1:0]          trace_rd_addr,
  output logic [DATA_WIDTH-1:0]          trace_rd_data,
  output logic                           trace_rd_valid,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_overflow,
  output logic [CNT_WIDTH-1:0]           cycle_count,
  output logic [CNT_WIDTH-1:0]           retire_count,
  output logic                           running,
  output logic                           halted,
  output logic                           timed_out,
  output logic                           done
);

  localparam int unsigned StallW = $clog2(HALT_CYCLES + 1);

  mon_state_e            state_q, state_d;
  logic [StallW-1:0]     stall_q, stall_d;
  logic [ADDR_WIDTH-1:0] prev_pc_q, prev_pc_d;
  logic                  prev_pc_valid_q, prev_pc_valid_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  retire_q, retire_d;

  logic                  run_active;
  logic                  pc_match;
  logic [StallW-1:0]     stall_inc;
  logic [CNT_WIDTH-1:0]  cycle_inc;
  logic [CNT_WIDTH-1:0]  retire_inc;
  logic                  halt_hit;
  logic                  timeout_hit;

  // Per-cycle observations; a clear cycle does no monitoring work.
  always_comb begin
    run_active  = (state_q == StRun) && enable && !clear;
    pc_match    = fetch_state && prev_pc_valid_q && (pc == prev_pc_q);
    stall_inc   = stall_q + 1'b1;
    cycle_inc   = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
    retire_inc  = (retire_q == '1) ? retire_q : retire_q + 1'b1;
    halt_hit    = pc_match && (stall_inc == StallW'(HALT_CYCLES));
    timeout_hit = (cycle_inc >= CNT_WIDTH'(TIMEOUT_CYCLES));
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; halt takes precedence over a coincident timeout.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) state_d = StRun;
        end
        StRun: begin
          if (!enable)          state_d = StIdle;
          else if (halt_hit)    state_d = StHalted;
          else if (timeout_hit) state_d = StTimeout;
        end
        StHalted, StTimeout: state_d = state_q;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    running   = (state_q == StRun);
    halted    = (state_q == StHalted);
    timed_out = (state_q == StTimeout);
    done      = halted || timed_out;
  end

  // Stall detector and saturating counters next state.
  always_comb begin
    stall_d         = stall_q;
    prev_pc_d       = prev_pc_q;
    prev_pc_valid_d = prev_pc_valid_q;
    cycle_d         = cycle_q;
    retire_d        = retire_q;
    if (clear) begin
      stall_d         = '0;
      prev_pc_d       = '0;
      prev_pc_valid_d = 1'b0;
      cycle_d         = '0;
      retire_d        = '0;
    end else if (run_active) begin
      stall_d         = pc_match ? stall_inc : '0;
      prev_pc_d       = pc;
      prev_pc_valid_d = 1'b1;
      cycle_d         = cycle_inc;
      if (retire) retire_d = retire_inc;
    end else if (state_q == StRun) begin
      // Pausing forgets the PC history so the stall run restarts on resume.
      stall_d         = '0;
      prev_pc_valid_d = 1'b0;
    end
  end

  // Stall detector and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q         <= '0;
      prev_pc_q       <= '0;
      prev_pc_valid_q <= 1'b0;
      cycle_q         <= '0;
      retire_q        <= '0;
    end else begin
      stall_q         <= stall_d;
      prev_pc_q       <= prev_pc_d;
      prev_pc_valid_q <= prev_pc_valid_d;
      cycle_q         <= cycle_d;
      retire_q        <= retire_d;
    end
  end

  // Counter outputs.
  always_comb begin
    cycle_count  = cycle_q;
    retire_count = retire_q;
  end

  trace_ring #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace_ring (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (run_active && mem_write),
    .wr_addr  (mem_addr),
    .wr_data  (mem_write_data),
    .rd_idx   (trace_rd_idx),
    .rd_addr  (trace_rd_addr),
    .rd_data  (trace_rd_data),
    .rd_valid (trace_rd_valid),
    .count    (trace_count),
    .overflow (trace_overflow)
  );

endmodule
